// File: rtl/io_tx_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : io_tx_buffer                                               |
// | Description : Transmit buffer between the core output instruction and    |
// |               the io_controller out_req/out_data/out_busy port. Holds    |
// |               up to 2**DEPTH_LOG2 entries; each entry is one byte or one |
// |               word, and a word leaves as four bytes, LSB first.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module io_tx_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WORD_W     = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push_req,
    input  logic [WORD_W-1:0]     push_data,
    input  logic                  push_word,
    output logic                  push_busy,
    output logic                  overflow,
    output logic                  out_req,
    output logic [WORD_W-1:0]     out_data,
    input  logic                  out_busy,
    output logic [DEPTH_LOG2:0]   fifo_count
);

    localparam int                  c_DEPTH   = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL    = (DEPTH_LOG2+1)'(c_DEPTH);

    localparam logic [1:0]          c_ST_IDLE = 2'd0;
    localparam logic [1:0]          c_ST_SEND = 2'd1;
    localparam logic [1:0]          c_ST_GAP  = 2'd2;

    // Entry layout: {mode, data}; mode=1 means all four bytes are sent.
    logic [WORD_W:0]           r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]     r_wr_ptr;
    logic [DEPTH_LOG2-1:0]     r_rd_ptr;
    logic [DEPTH_LOG2:0]       r_count;
    logic [1:0]                r_byte_idx;
    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic                      r_overflow;

    logic                      w_full;
    logic                      w_push;
    logic                      w_hs;
    logic                      w_last;
    logic                      w_pop;
    logic [WORD_W:0]           w_entry;
    logic [7:0]                w_byte;

    assign w_full  = (r_count == c_FULL);
    // A full buffer refuses a push even when a pop lands in the same cycle.
    assign w_push  = push_req && !w_full;
    assign w_entry = r_mem[r_rd_ptr];
    // Handshake: in SEND out_req is exactly !out_busy, so this is out_req && !out_busy.
    assign w_hs    = (r_state == c_ST_SEND) && !out_busy;
    assign w_last  = !w_entry[WORD_W] || (r_byte_idx == 2'd3);
    assign w_pop   = w_hs && w_last;

    assign push_busy  = w_full;
    assign overflow   = r_overflow;
    assign fifo_count = r_count;
    assign out_req    = w_hs;
    assign out_data   = (r_state == c_ST_SEND) ? {{(WORD_W-8){1'b0}}, w_byte} : '0;

    // Select the byte of the head entry currently being offered.
    always_comb begin
        w_byte = w_entry[7:0];
        case (r_byte_idx)
            2'd1:    w_byte = w_entry[15:8];
            2'd2:    w_byte = w_entry[23:16];
            2'd3:    w_byte = w_entry[31:24];
            default: w_byte = w_entry[7:0];
        endcase
    end

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {push_word, push_data};
        end
    end

    // Write/read pointers, entry count and sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push_req && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte index within a word entry; returns to 0 once the entry pops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_byte_idx <= 2'd0;
        end else if (w_hs) begin
            r_byte_idx <= w_last ? 2'd0 : r_byte_idx + 2'd1;
        end
    end

    // Output state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: GAP waits for out_busy so one accept never sees two requests.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (r_count != '0) w_state_nxt = c_ST_SEND;
            c_ST_SEND: if (w_hs)          w_state_nxt = c_ST_GAP;
            c_ST_GAP:  if (out_busy)      w_state_nxt = c_ST_IDLE;
            default:                      w_state_nxt = c_ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_io_tx_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_io_tx_buffer                                            |
// | Description : Directed self-checking bench for io_tx_buffer with a       |
// |               modelled io_controller consumer and a byte scoreboard.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_io_tx_buffer;

    localparam int c_DEPTH = 16;

    logic        clk;
    logic        rstn;
    logic        push_req;
    logic [31:0] push_data;
    logic        push_word;
    logic        push_busy;
    logic        overflow;
    logic        out_req;
    logic [31:0] out_data;
    logic        out_busy;
    logic [4:0]  fifo_count;

    logic        busy_force;
    logic        busy_cons;
    assign out_busy = busy_force | busy_cons;

    io_tx_buffer #(.DEPTH_LOG2(4), .WORD_W(32)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .push_req   (push_req),
        .push_data  (push_data),
        .push_word  (push_word),
        .push_busy  (push_busy),
        .overflow   (overflow),
        .out_req    (out_req),
        .out_data   (out_data),
        .out_busy   (out_busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors;
    int         checks;
    logic [7:0] exp_q[$];
    bit         last_q[$];
    int         mcount;
    bit         movf;
    bit         acc_pend;
    int         cons_cnt;
    int         cons_hold;
    int         got_cnt;
    logic [7:0] got_last;
    bit         last_pacc;
    bit         last_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic w);
        if (w) begin
            exp_q.push_back(d[7:0]);   last_q.push_back(1'b0);
            exp_q.push_back(d[15:8]);  last_q.push_back(1'b0);
            exp_q.push_back(d[23:16]); last_q.push_back(1'b0);
            exp_q.push_back(d[31:24]); last_q.push_back(1'b1);
        end else begin
            exp_q.push_back(d[7:0]);   last_q.push_back(1'b1);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_q.delete();
        mcount   = 0;
        movf     = 1'b0;
        acc_pend = 1'b0;
        busy_cons = 1'b0;
        cons_cnt = 0;
    endtask

    // One clock cycle: consumer model and scoreboard at the negedge, state checks after the posedge.
    task automatic tick();
        logic [7:0] eb;
        bit         el;
        @(negedge clk);
        if (acc_pend) begin
            acc_pend  = 1'b0;
            busy_cons = 1'b1;
            cons_cnt  = cons_hold;
        end else if (busy_cons) begin
            if (cons_cnt == 0) busy_cons = 1'b0;
            else               cons_cnt--;
        end
        #1;
        last_pop = 1'b0;
        if (out_req && !out_busy) begin
            acc_pend = 1'b1;
            got_cnt++;
            got_last = out_data[7:0];
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", out_data, 32'hFFFF_FFFF);
            end else begin
                eb = exp_q.pop_front();
                el = last_q.pop_front();
                chk("out_data", out_data, {24'h0, eb});
                last_pop = el;
            end
        end
        last_pacc = push_req && (mcount != c_DEPTH);
        if (push_req && !last_pacc) movf = 1'b1;
        if (last_pacc) push_exp(push_data, push_word);
        @(posedge clk);
        #1;
        mcount = mcount + int'(last_pacc) - int'(last_pop);
        chk("fifo_count", 32'(fifo_count), 32'(mcount));
        chk("push_busy", 32'(push_busy), 32'(mcount == c_DEPTH));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        repeat (4) tick();
    endtask

    task automatic push_one(input logic [31:0] d, input logic w);
        push_req  = 1'b1;
        push_data = d;
        push_word = w;
        tick();
        push_req  = 1'b0;
    endtask

    initial begin
        int n_push;
        int iter;
        int g0;
        errors     = 0;
        checks     = 0;
        cons_hold  = 0;
        got_cnt    = 0;
        got_last   = 8'h00;
        last_pacc  = 1'b0;
        last_pop   = 1'b0;
        busy_force = 1'b0;
        push_req   = 1'b0;
        push_data  = 32'h0;
        push_word  = 1'b0;
        model_reset();

        // Reset values.
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_push_busy", 32'(push_busy), 32'd0);
        chk("rst_out_req", 32'(out_req), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1: single byte, two-cycle latency.
        push_one(32'h0000_0041, 1'b0);
        chk("lat_no_req_early", 32'(out_req), 32'd0);
        tick();
        chk("lat_req", 32'(out_req), 32'd1);
        chk("lat_data", out_data, 32'h41);
        drain(50);
        chk("idle_no_req", 32'(out_req), 32'd0);

        // 2: word sent LSB first with a slower consumer.
        cons_hold = 1;
        g0 = got_cnt;
        push_one(32'h4433_2211, 1'b1);
        drain(100);
        chk("word_bytes", 32'(got_cnt - g0), 32'd4);
        chk("word_last", 32'(got_last), 32'h44);

        // 3: fill while consumer stalled, overflow on 17th push, then drain in order.
        cons_hold  = 0;
        busy_force = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) push_one(32'h60 + 32'(i), 1'b0);
        chk("full_busy", 32'(push_busy), 32'd1);
        chk("full_count", 32'(fifo_count), 32'd16);
        push_one(32'h0000_00EE, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        repeat (5) tick();
        chk("stall_hold_count", 32'(fifo_count), 32'd16);
        g0 = got_cnt;
        busy_force = 1'b0;
        drain(400);
        chk("drain16", 32'(got_cnt - g0), 32'd16);

        // 4: refused push during a full-buffer pop, accepted the next cycle.
        busy_force = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) push_one(32'hA0 + 32'(i), 1'b0);
        push_req   = 1'b1;
        push_data  = 32'h0000_0099;
        push_word  = 1'b0;
        busy_force = 1'b0;
        tick();
        chk("pop_while_full", 32'(last_pop), 32'd1);
        chk("refused_count", 32'(fifo_count), 32'd15);
        tick();
        chk("retry_accepted", 32'(last_pacc), 32'd1);
        chk("retry_count", 32'(fifo_count), 32'd16);
        push_req = 1'b0;

        // Wrap: 40 mixed pushes interleaved with pops.
        n_push = 0;
        iter   = 0;
        while (n_push < 40 && iter < 3000) begin
            push_req  = (mcount < c_DEPTH) && ($urandom_range(0, 1) == 1);
            push_word = ($urandom_range(0, 2) == 0);
            push_data = $urandom;
            cons_hold = $urandom_range(0, 2);
            tick();
            if (last_pacc) n_push++;
            iter++;
        end
        push_req = 1'b0;
        chk("wrap_pushes", 32'(n_push), 32'd40);
        drain(3000);

        // 5: asynchronous reset with a word half sent.
        cons_hold = 1;
        g0 = got_cnt;
        push_one(32'hD4C3_B2A1, 1'b1);
        iter = 0;
        while ((got_cnt - g0) < 2 && iter < 100) begin
            tick();
            iter++;
        end
        chk("half_sent", 32'(got_cnt - g0), 32'd2);
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_req", 32'(out_req), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        model_reset();
        @(negedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        g0 = got_cnt;
        push_one(32'h0000_0055, 1'b0);
        drain(100);
        chk("post_rst_bytes", 32'(got_cnt - g0), 32'd1);
        chk("post_rst_byte", 32'(got_last), 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
